// File: rtl/rename_map_table.sv
// Speculative register alias table for a 3-wide rename stage: combinational lookups with
// in-group forwarding and CDB bypass, ready bits per physical register, and full restore on mispredict.
module rename_map_table #(
  parameter int PRW  = 6,
  parameter int NAR  = 32,
  parameter int WAYS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WAYS-1:0]       dispatch_en,
  input  logic [WAYS*5-1:0]     dest_ar,
  input  logic [WAYS-1:0]       has_dest,
  input  logic [WAYS*5-1:0]     src1_ar,
  input  logic [WAYS*5-1:0]     src2_ar,
  input  logic [WAYS*PRW-1:0]   Tnew,
  input  logic [WAYS-1:0]       cdb_valid,
  input  logic [WAYS*PRW-1:0]   cdb_tag,
  input  logic                  BPRecoverEN,
  input  logic [NAR*PRW-1:0]    recover_maptable,
  output logic [WAYS*PRW-1:0]   Told,
  output logic [WAYS*PRW-1:0]   src1_pr,
  output logic [WAYS*PRW-1:0]   src2_pr,
  output logic [WAYS-1:0]       src1_rdy,
  output logic [WAYS-1:0]       src2_rdy
);

  localparam int NPR = 1 << PRW;

  logic [PRW-1:0] map_q [NAR];
  logic [NPR-1:0] rdy_q;
  logic [NPR-1:0] rdy_nxt;
  logic [WAYS-1:0] writes;

  // Per-way lookup results; slot 0 = src1, 1 = src2, 2 = dest (Told).
  logic [PRW-1:0] look_pr  [WAYS][3];
  logic           look_rdy [WAYS][3];

  always_comb begin
    for (int unsigned k = 0; k < WAYS; k++) begin
      writes[k] = dispatch_en[k] & has_dest[k] & (dest_ar[k*5 +: 5] != 5'd0);
    end
  end

  always_comb begin
    logic [4:0] ar;
    ar = '0;
    for (int unsigned k = 0; k < WAYS; k++) begin
      for (int unsigned s = 0; s < 3; s++) begin
        case (s)
          0:       ar = src1_ar[k*5 +: 5];
          1:       ar = src2_ar[k*5 +: 5];
          default: ar = dest_ar[k*5 +: 5];
        endcase
        look_pr[k][s]  = map_q[ar];
        look_rdy[k][s] = rdy_q[look_pr[k][s]];
        for (int unsigned c = 0; c < WAYS; c++) begin
          if (cdb_valid[c] && (cdb_tag[c*PRW +: PRW] == look_pr[k][s])) begin
            look_rdy[k][s] = 1'b1;
          end
        end
        // Walk older ways from oldest towards k so the youngest older match overrides.
        for (int unsigned j = WAYS - 1; j > k; j--) begin
          if (writes[j] && (dest_ar[j*5 +: 5] == ar)) begin
            look_pr[k][s]  = Tnew[j*PRW +: PRW];
            look_rdy[k][s] = 1'b0;
          end
        end
        if (ar == 5'd0) begin
          look_pr[k][s]  = '0;
          look_rdy[k][s] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    Told     = '0;
    src1_pr  = '0;
    src2_pr  = '0;
    src1_rdy = '0;
    src2_rdy = '0;
    for (int unsigned k = 0; k < WAYS; k++) begin
      src1_pr[k*PRW +: PRW] = look_pr[k][0];
      src2_pr[k*PRW +: PRW] = look_pr[k][1];
      Told[k*PRW +: PRW]    = look_pr[k][2];
      src1_rdy[k]           = look_rdy[k][0];
      src2_rdy[k]           = look_rdy[k][1];
    end
  end

  // CDB sets are applied first so a same-cycle dispatch of that PR clears it.
  always_comb begin
    rdy_nxt = rdy_q;
    for (int unsigned c = 0; c < WAYS; c++) begin
      if (cdb_valid[c]) rdy_nxt[cdb_tag[c*PRW +: PRW]] = 1'b1;
    end
    for (int unsigned j = 0; j < WAYS; j++) begin
      if (writes[j]) rdy_nxt[Tnew[j*PRW +: PRW]] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NAR; i++) map_q[i] <= PRW'(i);
      rdy_q <= '1;
    end else if (BPRecoverEN) begin
      for (int unsigned i = 0; i < NAR; i++) map_q[i] <= recover_maptable[i*PRW +: PRW];
      rdy_q <= '1;
    end else begin
      rdy_q <= rdy_nxt;
      // Oldest first so the youngest writer of a shared AR lands last.
      for (int unsigned j = WAYS; j > 0; j--) begin
        if (writes[j-1]) map_q[dest_ar[(j-1)*5 +: 5]] <= Tnew[(j-1)*PRW +: PRW];
      end
    end
  end

endmodule
